// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Y86-64 M-stage initiator with valid/ready data-memory request/response port
// Optional abort of stuck accesses after TIMEOUT cycles: define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_icode,
  input  logic [63:0]       M_ValA,
  input  logic [63:0]       M_ValE,
  input  logic [3:0]        M_stat,
  output logic [63:0]       m_ValM,
  output logic [3:0]        m_stat,
  output logic              dmem_err,
  output logic              mem_stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [63:0]       req_wdata,
  input  logic              rsp_valid,
  input  logic [63:0]       rsp_rdata,
  input  logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        is_mem_icode;
  logic        is_write;
  logic        mem_op;
  logic        out_of_range;
  logic [63:0] addr;
  logic        timed_out;

  always_comb begin
    is_mem_icode = M_icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    is_write     = M_icode inside {4'd4, 4'd8, 4'd10};
    mem_op       = (M_stat == 4'h1) && is_mem_icode;
    // ret/popq address through ValA (stack pointer), the rest through ValE
    addr         = (M_icode inside {4'd9, 4'd11}) ? M_ValA : M_ValE;
    out_of_range = addr[63] || (addr >= 64'(DEPTH));
  end

  assign mem_stall = mem_op && (state != DONE);
  assign m_stat    = dmem_err ? 4'h3 : M_stat;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timed_out = (state == REQ || state == WAIT) && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      m_ValM    <= '0;
      dmem_err  <= 1'b0;
    end else if (timed_out) begin
      req_valid <= 1'b0;
      dmem_err  <= 1'b1;
      state     <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && out_of_range) begin
            dmem_err <= 1'b1;
            state    <= DONE;
          end else if (mem_op) begin
            req_we    <= is_write;
            req_addr  <= addr[ADDR_W-1:0];
            req_wdata <= M_ValA;
            req_valid <= 1'b1;
            dmem_err  <= 1'b0;
            state     <= REQ;
          end else begin
            dmem_err <= 1'b0;
          end
        end
        REQ: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (!req_we) begin
              m_ValM <= rsp_rdata;
            end
            dmem_err <= rsp_err;
            state    <= DONE;
          end
        end
        DONE: begin
          dmem_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - cycle-table bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M_icode;
  logic [63:0] M_ValA;
  logic [63:0] M_ValE;
  logic [3:0]  M_stat;
  logic [63:0] m_ValM;
  logic [3:0]  m_stat;
  logic        dmem_err;
  logic        mem_stall;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_ctrl #(.DEPTH(1024), .ADDR_W(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .M_icode(M_icode), .M_ValA(M_ValA), .M_ValE(M_ValE), .M_stat(M_stat),
    .m_ValM(m_ValM), .m_stat(m_stat), .dmem_err(dmem_err), .mem_stall(mem_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vala;
    logic [63:0] vale;
    logic [3:0]  stat;
    logic        rdy;
    logic        rv;
    logic [63:0] rdata;
    logic        rerr;
    logic        x_stall;
    logic        x_rvalid;
    logic        x_we;
    logic [9:0]  x_addr;
    logic [63:0] x_wdata;
    logic [63:0] x_valm;
    logic [3:0]  x_mstat;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] M5 = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

  task automatic add(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                     input logic [3:0] st, input logic rd, input logic rv, input logic [63:0] rdt,
                     input logic re, input logic xs, input logic xv, input logic xw,
                     input logic [9:0] xa, input logic [63:0] xd, input logic [63:0] xm,
                     input logic [3:0] xst, input logic xe);
    vec_t v;
    v.icode = ic; v.vala = va; v.vale = ve; v.stat = st; v.rdy = rd; v.rv = rv;
    v.rdata = rdt; v.rerr = re; v.x_stall = xs; v.x_rvalid = xv; v.x_we = xw;
    v.x_addr = xa; v.x_wdata = xd; v.x_valm = xm; v.x_mstat = xst; v.x_err = xe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                       input logic [3:0] st, input logic rd, input logic rv,
                       input logic [63:0] rdt, input logic re);
    M_icode = ic; M_ValA = va; M_ValE = ve; M_stat = st;
    req_ready = rd; rsp_valid = rv; rsp_rdata = rdt; rsp_err = re;
  endtask

  initial begin
    //   icode vala   vale   st rdy rv rdata       rerr| stall rv we addr  wdata  valm        mstat err
    add(4'd0,  0,     0,     1, 1, 0, 0,           0,   0, 0, 0, 0,    0,     0,           1, 0); // r0 idle
    add(4'd5,  0,     40,    1, 1, 0, 0,           0,   1, 0, 0, 0,    0,     0,           1, 0); // r1 mrmovq IDLE
    add(4'd5,  0,     40,    1, 1, 0, 0,           0,   1, 1, 0, 40,   0,     0,           1, 0); // r2 REQ
    add(4'd5,  0,     40,    1, 1, 1, 64'hABCD,    0,   1, 0, 0, 40,   0,     0,           1, 0); // r3 WAIT
    add(4'd5,  0,     40,    1, 1, 0, 0,           0,   0, 0, 0, 40,   0,     64'hABCD,    1, 0); // r4 DONE
    add(4'd6,  0,     0,     4, 1, 0, 0,           0,   0, 0, 0, 40,   0,     64'hABCD,    4, 0); // r5 OPq bad stat
    add(4'd4,  M5,    7,     1, 0, 0, 0,           0,   1, 0, 0, 40,   0,     64'hABCD,    1, 0); // r6 rmmovq IDLE
    for (int i = 0; i < 4; i++)
      add(4'd4, M5,   7,     1, 0, 0, 0,           0,   1, 1, 1, 7,    M5,    64'hABCD,    1, 0); // r7-10 REQ stalled
    add(4'd4,  M5,    7,     1, 1, 0, 0,           0,   1, 1, 1, 7,    M5,    64'hABCD,    1, 0); // r11 handshake
    add(4'd4,  M5,    7,     1, 1, 0, 0,           0,   1, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r12 WAIT
    add(4'd4,  M5,    7,     1, 1, 1, 64'h1111,    0,   1, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r13 WAIT rsp
    add(4'd4,  M5,    7,     1, 1, 0, 0,           0,   0, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r14 DONE
    add(4'd11, 1024,  0,     1, 1, 0, 0,           0,   1, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r15 popq oor
    add(4'd11, 1024,  0,     1, 1, 0, 0,           0,   0, 0, 1, 7,    M5,    64'hABCD,    3, 1); // r16 DONE err
    add(4'd10, 3,     M8,    1, 1, 0, 0,           0,   1, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r17 pushq neg
    add(4'd10, 3,     M8,    1, 1, 0, 0,           0,   0, 0, 1, 7,    M5,    64'hABCD,    3, 1); // r18 DONE err
    add(4'd5,  0,     1023,  1, 1, 0, 0,           0,   1, 0, 1, 7,    M5,    64'hABCD,    1, 0); // r19 top word
    add(4'd5,  0,     1023,  1, 1, 0, 0,           0,   1, 1, 0, 1023, 0,     64'hABCD,    1, 0); // r20 REQ
    add(4'd5,  0,     1023,  1, 1, 1, 64'h55,      0,   1, 0, 0, 1023, 0,     64'hABCD,    1, 0); // r21 WAIT
    add(4'd5,  0,     1023,  1, 1, 0, 0,           0,   0, 0, 0, 1023, 0,     64'h55,      1, 0); // r22 DONE
    add(4'd9,  16,    0,     1, 1, 0, 0,           0,   1, 0, 0, 1023, 0,     64'h55,      1, 0); // r23 ret
    add(4'd9,  16,    0,     1, 1, 0, 0,           0,   1, 1, 0, 16,   16,    64'h55,      1, 0); // r24 REQ
    add(4'd9,  16,    0,     1, 1, 1, 64'h77,      1,   1, 0, 0, 16,   16,    64'h55,      1, 0); // r25 WAIT rsp_err
    add(4'd9,  16,    0,     1, 1, 0, 0,           0,   0, 0, 0, 16,   16,    64'h77,      3, 1); // r26 DONE err
    add(4'd1,  0,     0,     1, 1, 1, 64'h99,      1,   0, 0, 0, 16,   16,    64'h77,      1, 0); // r27 stray rsp
    add(4'd1,  0,     0,     1, 1, 0, 0,           0,   0, 0, 0, 16,   16,    64'h77,      1, 0); // r28 ignored
    add(4'd5,  0,     8,     2, 1, 0, 0,           0,   0, 0, 0, 16,   16,    64'h77,      2, 0); // r29 HLT passes
    add(4'd5,  0,     8,     2, 1, 0, 0,           0,   0, 0, 0, 16,   16,    64'h77,      2, 0); // r30 no request

    rst = 1'b1;
    drive(4'd0, 0, 0, 4'd1, 1'b1, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_valid", 64'(req_valid), 0);
    chk("reset req_we", 64'(req_we), 0);
    chk("reset req_addr", 64'(req_addr), 0);
    chk("reset req_wdata", req_wdata, 0);
    chk("reset m_ValM", m_ValM, 0);
    chk("reset dmem_err", 64'(dmem_err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].vala, vecs[i].vale, vecs[i].stat,
            vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].rerr);
      #1;
      chk($sformatf("r%0d mem_stall", i), 64'(mem_stall), 64'(vecs[i].x_stall));
      chk($sformatf("r%0d req_valid", i), 64'(req_valid), 64'(vecs[i].x_rvalid));
      chk($sformatf("r%0d req_we", i), 64'(req_we), 64'(vecs[i].x_we));
      chk($sformatf("r%0d req_addr", i), 64'(req_addr), 64'(vecs[i].x_addr));
      chk($sformatf("r%0d req_wdata", i), req_wdata, vecs[i].x_wdata);
      chk($sformatf("r%0d m_ValM", i), m_ValM, vecs[i].x_valm);
      chk($sformatf("r%0d m_stat", i), 64'(m_stat), 64'(vecs[i].x_mstat));
      chk($sformatf("r%0d dmem_err", i), 64'(dmem_err), 64'(vecs[i].x_err));
    end

    // reset while waiting for a response, then a late response must be dropped
    @(negedge clk);
    drive(4'd5, 0, 3, 4'd1, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    #1;
    chk("rstw REQ req_valid", 64'(req_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    drive(4'd1, 0, 0, 4'd1, 1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("rstw req_valid", 64'(req_valid), 0);
    chk("rstw req_addr", 64'(req_addr), 0);
    chk("rstw req_we", 64'(req_we), 0);
    chk("rstw m_ValM", m_ValM, 0);
    chk("rstw dmem_err", 64'(dmem_err), 0);
    chk("rstw mem_stall", 64'(mem_stall), 0);
    @(negedge clk);
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'hDEAD;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk("late rsp m_ValM", m_ValM, 0);
    chk("late rsp req_valid", 64'(req_valid), 0);
    chk("late rsp dmem_err", 64'(dmem_err), 0);
    chk("late rsp m_stat", 64'(m_stat), 1);

`ifdef MEM_TIMEOUT_EN
    begin
      int  hi;
      bit  seen;
      bit  dropped;
      hi = 0; seen = 1'b0; dropped = 1'b0;
      @(negedge clk);
      drive(4'd5, 0, 2, 4'd1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 40 && !dropped; i++) begin
        @(negedge clk);
        #1;
        if (req_valid) begin
          hi++;
          seen = 1'b1;
        end else if (seen) begin
          dropped = 1'b1;
        end
      end
      chk("timeout dropped", 64'(dropped), 1);
      chk("timeout req_valid cycles", 64'(hi), 16);
      chk("timeout m_stat", 64'(m_stat), 3);
      chk("timeout mem_stall", 64'(mem_stall), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
